// File: rtl/sm_uart_pkg.sv
// Shared constants, state types and the nibble-to-ASCII helper for the register-dump UART.
// Used by sm_uart_reg_dump and sm_uart_tx.
package sm_uart_pkg;

    localparam logic [7:0] CHAR_R  = 8'h72;
    localparam logic [7:0] CHAR_EQ = 8'h3D;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam int unsigned LINE_LEN = 14;

    typedef enum logic [1:0] {CtrlIdle, CtrlLoad, CtrlSend, CtrlDone} ctrl_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// 8N1 byte serialiser with a valid/ready handshake; each bit lasts DIV clocks.
// Reusable for other UART blocks.
module sm_uart_tx
    import sm_uart_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_txd
);

    if (DIV < 2) begin : g_bad_div
        $error("sm_uart_tx: DIV must be at least 2");
    end

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST      = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_STOP_LAST = CW'(DIV - 2);

    tx_state_e     r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_shift, w_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TxIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
        end
    end

    // STOP holds for DIV-1 clocks; its final clock is spent in IDLE (line high, ready=1),
    // so a byte offered then starts with no gap and the stop bit is still exactly DIV long.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        o_ready = 1'b0;
        o_txd   = 1'b1;
        unique case (r_state)
            TxIdle: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_shift = i_data;
                    w_cnt   = '0;
                    w_state = TxStart;
                end
            end
            TxStart: begin
                o_txd = 1'b0;
                if (r_cnt == CNT_LAST) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_state = TxData;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            TxData: begin
                o_txd = r_shift[0];
                if (r_cnt == CNT_LAST) begin
                    w_cnt   = '0;
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state = TxStop;
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            TxStop: begin
                if (r_cnt == CNT_STOP_LAST) begin
                    w_cnt   = '0;
                    w_state = TxIdle;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/sm_uart_reg_dump.sv
// Snapshots {regAddr, regData} on request and sends "rAA=DDDDDDDD\r\n" over txd (8N1).
// Optional SM_UART_DUMP_AUTO_EN: also dump automatically whenever the inputs change.
module sm_uart_reg_dump
    import sm_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        busy,
    output logic        txd
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

    ctrl_state_e r_state, w_state;
    logic [3:0]  r_idx, w_idx;
    logic [4:0]  r_addr;
    logic [31:0] r_data;

    logic        w_trigger;
    logic        w_accept;
    logic        w_tx_valid;
    logic        w_tx_ready;
    logic [7:0]  w_byte;
    logic [3:0]  w_nib;

`ifdef SM_UART_DUMP_AUTO_EN
    logic [36:0] r_shadow;

    assign w_trigger = start | ({regAddr, regData} != r_shadow);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_accept) begin
            r_shadow <= {regAddr, regData};
        end
    end
`else
    assign w_trigger = start;
`endif

    assign busy     = (r_state != CtrlIdle);
    assign w_accept = ~busy & w_trigger;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CtrlIdle;
            r_idx   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            if (w_accept) begin
                r_addr <= regAddr;
                r_data <= regData;
            end
        end
    end

    // Data nibbles occupy indices 4..11, most significant first.
    always_comb begin
        w_nib = 4'(r_data >> {4'd11 - r_idx, 2'b00});
        case (r_idx)
            4'd0:    w_byte = CHAR_R;
            4'd1:    w_byte = nib2ascii({3'b000, r_addr[4]});
            4'd2:    w_byte = nib2ascii(r_addr[3:0]);
            4'd3:    w_byte = CHAR_EQ;
            4'd12:   w_byte = CHAR_CR;
            4'd13:   w_byte = CHAR_LF;
            default: w_byte = nib2ascii(w_nib);
        endcase
    end

    // Byte 0 is the constant 'r', so it is handed over in the accepting cycle itself;
    // that puts the first start bit on the very next edge.
    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_tx_valid = 1'b0;
        unique case (r_state)
            CtrlIdle: begin
                w_tx_valid = w_accept;
                if (w_accept) begin
                    w_idx   = 4'd1;
                    w_state = CtrlLoad;
                end
            end
            CtrlLoad, CtrlSend: begin
                w_tx_valid = 1'b1;
                w_state    = CtrlSend;
                if (w_tx_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx   = '0;
                        w_state = CtrlDone;
                    end else begin
                        w_idx = r_idx + 4'd1;
                    end
                end
            end
            CtrlDone: begin
                if (w_tx_ready) begin
                    w_state = CtrlIdle;
                end
            end
        endcase
    end

    sm_uart_tx #(
        .DIV(DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .i_valid(w_tx_valid),
        .i_data (w_byte),
        .o_ready(w_tx_ready),
        .o_txd  (txd)
    );

endmodule

// File: tb/tb_sm_uart_reg_dump.sv
// Directed bench for sm_uart_reg_dump at DIV=10; define SM_UART_DUMP_AUTO_EN for the auto test.
module tb_sm_uart_reg_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        busy;
    logic        txd;

    int n_tests = 0;
    int n_fail  = 0;

    sm_uart_reg_dump #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .regAddr(regAddr),
        .regData(regData),
        .busy   (busy),
        .txd    (txd)
    );

    always #5 clk = ~clk;

    // Expected 14-byte line, byte 0 in the top bits: 12 printable chars then CR LF.
    function automatic logic [111:0] mk_line(input string s);
        logic [111:0] v;
        v = '0;
        for (int i = 0; i < 12; i++) begin
            v[111 - 8*i -: 8] = s[i];
        end
        v[15:8] = 8'h0D;
        v[7:0]  = 8'h0A;
        return v;
    endfunction

    // Samples 1400 consecutive cycles starting now (first start bit expected now).
    // bad counts cycles with busy low, a bit not held for 10 cycles, or a bad start/stop bit.
    task automatic rx_line(output logic [111:0] line, output int bad);
        logic first;
        line  = '0;
        bad   = 0;
        first = 1'b0;
        for (int j = 0; j < 1400; j++) begin
            int k;
            k = (j / 10) % 10;
            if (j > 0) @(negedge clk);
            if (busy !== 1'b1) bad++;
            if (j % 10 == 0) begin
                first = txd;
                if (k == 0 && txd !== 1'b0) bad++;
                if (k == 9 && txd !== 1'b1) bad++;
            end else if (txd !== first) begin
                bad++;
            end
            if (j % 10 == 5 && k >= 1 && k <= 8) begin
                line[(13 - j / 100) * 8 + (k - 1)] = txd;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

`ifdef SM_UART_DUMP_AUTO_EN

    task automatic test_auto();
        logic [111:0] got;
        int bad;
        int quiet;
        rst = 1'b1; start = 1'b0; regAddr = 5'h00; regData = 32'h1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rx_line(got, bad);
        n_tests++;
        if (got !== mk_line("r00=00000001")) begin
            n_fail++; $display("FAIL auto_line1: got %h want %h", got, mk_line("r00=00000001"));
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL auto_timing1: got %0d bad cycles want 0", bad); end
        quiet = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) quiet++;
        end
        n_tests++;
        if (quiet != 0) begin n_fail++; $display("FAIL auto_stable: got %0d active cycles want 0", quiet); end
        regData = 32'h2;
        @(negedge clk);
        rx_line(got, bad);
        n_tests++;
        if (got !== mk_line("r00=00000002")) begin
            n_fail++; $display("FAIL auto_line2: got %h want %h", got, mk_line("r00=00000002"));
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL auto_timing2: got %0d bad cycles want 0", bad); end
        quiet = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) quiet++;
        end
        n_tests++;
        if (quiet != 0) begin n_fail++; $display("FAIL auto_stable2: got %0d active cycles want 0", quiet); end
    endtask

`else

    task automatic test_reset();
        int bad;
        bad = 0;
        rst = 1'b1; start = 1'b0; regAddr = '0; regData = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_idle: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_line();
        logic [111:0] got;
        int bad;
        regAddr = 5'h05; regData = 32'hDEADBEEF;
        pulse_start();
        rx_line(got, bad);
        n_tests++;
        if (got !== mk_line("r05=DEADBEEF")) begin
            n_fail++; $display("FAIL line_content: got %h want %h", got, mk_line("r05=DEADBEEF"));
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL line_timing: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            n_fail++; $display("FAIL line_end: got busy=%b txd=%b want busy=0 txd=1", busy, txd);
        end
    endtask

    task automatic test_snapshot();
        logic [111:0] got;
        int bad;
        regAddr = 5'h1F; regData = 32'h0000000A;
        pulse_start();
        fork
            rx_line(got, bad);
            begin
                repeat (700) @(negedge clk);
                regData = 32'h12345678;
                regAddr = 5'h02;
            end
        join
        n_tests++;
        if (got !== mk_line("r1F=0000000A")) begin
            n_fail++; $display("FAIL snapshot_content: got %h want %h", got, mk_line("r1F=0000000A"));
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL snapshot_timing: got %0d bad cycles want 0", bad); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [111:0] got;
        int bad;
        regAddr = 5'h03; regData = 32'hCAFEF00D;
        pulse_start();
        fork
            rx_line(got, bad);
            begin
                repeat (500) @(negedge clk);
                start = 1'b1; regAddr = 5'h0A; regData = 32'h0123ABCD;
                @(negedge clk);
                start = 1'b0;
            end
        join
        n_tests++;
        if (got !== mk_line("r03=CAFEF00D")) begin
            n_fail++; $display("FAIL b2b_line1: got %h want %h", got, mk_line("r03=CAFEF00D"));
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_timing1: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            n_fail++; $display("FAIL b2b_no_queue: got busy=%b txd=%b want busy=0 txd=1", busy, txd);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rx_line(got, bad);
        n_tests++;
        if (got !== mk_line("r0A=0123ABCD")) begin
            n_fail++; $display("FAIL b2b_line2: got %h want %h", got, mk_line("r0A=0123ABCD"));
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_timing2: got %0d bad cycles want 0", bad); end
        @(negedge clk);
    endtask

    task automatic test_reset_midline();
        logic [111:0] got;
        int bad;
        int idle_bad;
        regAddr = 5'h02; regData = 32'h00000003;
        pulse_start();
        repeat (415) @(negedge clk);
        n_tests++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midline_pre: got busy=%b txd=%b want busy=1 txd=0", busy, txd);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midline_abort: got busy=%b txd=%b want busy=0 txd=1", busy, txd);
        end
        rst = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        n_tests++;
        if (idle_bad != 0) begin
            n_fail++; $display("FAIL midline_idle: got %0d active cycles want 0", idle_bad);
        end
        regAddr = 5'h10; regData = 32'h89ABCDEF;
        pulse_start();
        rx_line(got, bad);
        n_tests++;
        if (got !== mk_line("r10=89ABCDEF")) begin
            n_fail++; $display("FAIL midline_after: got %h want %h", got, mk_line("r10=89ABCDEF"));
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL midline_timing: got %0d bad cycles want 0", bad); end
        @(negedge clk);
    endtask

`endif

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        regAddr = '0;
        regData = '0;
`ifdef SM_UART_DUMP_AUTO_EN
        test_auto();
`else
        test_reset();
        test_line();
        test_snapshot();
        test_back_to_back();
        test_reset_midline();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
